lfsr_sched: RTL and testbench

LFSR_SCHED -- requirements
Module: lfsr_sched

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_sched_rr_pick.sv | 35 +++
 rtl/lfsr_sched.sv | 153 +++++++++++++++
 tb/tb_lfsr_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pkg
//  Purpose  : Shared types and constants for the LFSR-backed grant scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_W    = 247;
    localparam int GNT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_WARM = 2'd1,
        ST_IDLE = 2'd2,
        ST_GNT  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin pick: first set req bit strictly after
//             the last-granted index, wrapping to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    // Wrapped candidates (index <= last) go first so the strictly-after pass overrides them.
    always_comb begin
        any    = |req;
        winner = last;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(last))) begin
                winner = IDX_W'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last))) begin
                winner = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_sched
//  Purpose  : Seeds and warms an external 247-bit LFSR, then hands fresh random
//             words to requesters in round-robin order, one grant per 2 cycles.
//  Options  : LFSR_SCHED_CNT_EN adds per-requester saturating grant counters.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_sched
    import lfsr_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int OUT_W  = 32,
    parameter int WARMUP = 16
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    output logic [OUT_W-1:0]      rnd,
    output logic                  ready,
    output logic                  lfsr_init,
    output logic                  lfsr_next,
    input  logic [LFSR_W-1:0]     lfsr_value
`ifdef LFSR_SCHED_CNT_EN
    ,
    output logic [NREQ*GNT_CNT_W-1:0] gnt_cnt
`endif
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int WCNT_W = $clog2(WARMUP + 1);
    localparam logic [IDX_W-1:0]  C_LAST_RST  = IDX_W'(NREQ - 1);
    localparam logic [WCNT_W-1:0] C_WARM_LOAD = WCNT_W'(WARMUP);
    localparam logic [WCNT_W-1:0] C_WARM_LAST = WCNT_W'(1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic              r_seed_done;
    logic [WCNT_W-1:0] r_warm_cnt;
    logic [IDX_W-1:0]  r_winner;
    logic [IDX_W-1:0]  r_last;
    logic [OUT_W-1:0]  r_rnd;
    logic              w_any;
    logic [IDX_W-1:0]  w_pick;
    logic              w_unused_lfsr;

    // Only the low OUT_W bits feed rnd; the rest of the LFSR state is deliberately unused.
    assign w_unused_lfsr = ^lfsr_value;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .last   (r_last),
        .any    (w_any),
        .winner (w_pick)
    );

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state <= ST_SEED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        lfsr_init   = 1'b0;
        lfsr_next   = 1'b0;
        ready       = 1'b0;
        gnt         = '0;
        case (r_state)
            ST_SEED: begin
                lfsr_init = 1'b1;
                if (r_seed_done) begin
                    w_state_nxt = ST_WARM;
                end
            end
            ST_WARM: begin
                lfsr_next = 1'b1;
                if (r_warm_cnt <= C_WARM_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
                if (w_any) begin
                    w_state_nxt = ST_GNT;
                end
            end
            ST_GNT: begin
                ready       = 1'b1;
                lfsr_next   = 1'b1;
                gnt         = NREQ'(1) << r_winner;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_SEED;
            end
        endcase
    end

    // The word is captured on the same edge that latches the winner.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_seed_done <= 1'b0;
            r_warm_cnt  <= C_WARM_LOAD;
            r_winner    <= C_LAST_RST;
            r_last      <= C_LAST_RST;
            r_rnd       <= '0;
        end else begin
            case (r_state)
                ST_SEED: r_seed_done <= 1'b1;
                ST_WARM: begin
                    if (r_warm_cnt != '0) begin
                        r_warm_cnt <= r_warm_cnt - C_WARM_LAST;
                    end
                end
                ST_IDLE: begin
                    if (w_any) begin
                        r_winner <= w_pick;
                        r_rnd    <= lfsr_value[OUT_W-1:0];
                    end
                end
                ST_GNT:  r_last <= r_winner;
                default: r_seed_done <= 1'b0;
            endcase
        end
    end

    assign rnd = r_rnd;

`ifdef LFSR_SCHED_CNT_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        logic [GNT_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or posedge init) begin
            if (init) begin
                r_cnt <= '0;
            end else if ((r_state == ST_GNT) && (r_winner == IDX_W'(gi)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + GNT_CNT_W'(1);
            end
        end

        assign gnt_cnt[gi*GNT_CNT_W +: GNT_CNT_W] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_sched
//  Purpose  : Self-checking bench for lfsr_sched with an LFSR stand-in and a
//             cycle-level reference model of the grant schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_sched;
    import lfsr_pkg::*;

    localparam int NREQ   = 4;
    localparam int OUT_W  = 32;
    localparam int WARMUP = 16;
    localparam int T_RDY  = 2 + WARMUP;

    logic              clk;
    logic              init;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [OUT_W-1:0]  rnd;
    logic              ready;
    logic              lfsr_init;
    logic              lfsr_next;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] seed;
`ifdef LFSR_SCHED_CNT_EN
    logic [NREQ*GNT_CNT_W-1:0] gnt_cnt;
`endif

    lfsr_sched #(
        .NREQ   (NREQ),
        .OUT_W  (OUT_W),
        .WARMUP (WARMUP)
    ) dut (
        .clk        (clk),
        .init       (init),
        .req        (req),
        .gnt        (gnt),
        .rnd        (rnd),
        .ready      (ready),
        .lfsr_init  (lfsr_init),
        .lfsr_next  (lfsr_next),
        .lfsr_value (lfsr_q)
`ifdef LFSR_SCHED_CNT_EN
        ,
        .gnt_cnt    (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external lfsr247 block.
    always @(posedge clk) begin
        if (lfsr_init)      lfsr_q <= seed;
        else if (lfsr_next) lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[246] ^ lfsr_q[164]};
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: t = rising edges since init released, e_gnt = index granted this cycle.
    int               t;
    int               e_gnt;
    int               m_last;
    logic [OUT_W-1:0] e_rnd;
    int               m_cnt [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        t      = 0;
        e_gnt  = -1;
        m_last = NREQ - 1;
        e_rnd  = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic check_all();
        logic [NREQ-1:0] eg;
        eg = (e_gnt >= 0) ? NREQ'(1) << e_gnt : '0;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("rnd", 64'(rnd), 64'(e_rnd));
        chk("ready", 64'(ready), 64'(t >= T_RDY));
        chk("lfsr_init", 64'(lfsr_init), 64'(t < 2));
        chk("lfsr_next", 64'(lfsr_next), 64'((t >= 2 && t < T_RDY) || e_gnt >= 0));
        chk("init_next_excl", 64'(lfsr_init & lfsr_next), 64'(0));
`ifdef LFSR_SCHED_CNT_EN
        for (int i = 0; i < NREQ; i++)
            chk("gnt_cnt", 64'(gnt_cnt[i*GNT_CNT_W +: GNT_CNT_W]),
                64'((m_cnt[i] > 65535) ? 65535 : m_cnt[i]));
`endif
    endtask

    // Called at a falling edge: drive req, predict the next cycle, advance, check.
    task automatic step(input logic [NREQ-1:0] r);
        int n_gnt;
        req   = r;
        n_gnt = -1;
        if (t >= T_RDY && e_gnt < 0 && r != '0) begin
            n_gnt = rr(m_last, r);
            e_rnd = lfsr_q[OUT_W-1:0];
        end
        if (e_gnt >= 0) begin
            m_last = e_gnt;
            m_cnt[e_gnt]++;
        end
        e_gnt = n_gnt;
        t++;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [255:0]     tmp;
        logic [OUT_W-1:0] prev_rnd;
        int               pulses;
        int               nexts;
        int               first_t;
        int               tries;

        tmp  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        seed = tmp[LFSR_W-1:0] | LFSR_W'(1);
        init = 1'b1;
        req  = '0;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 64'(gnt), 64'(0));
            chk("rst_rnd", 64'(rnd), 64'(0));
            chk("rst_ready", 64'(ready), 64'(0));
            chk("rst_lfsr_init", 64'(lfsr_init), 64'(1));
            chk("rst_lfsr_next", 64'(lfsr_next), 64'(0));
        end
        init = 1'b0;
        #1;
        check_all();

        // Request raised mid warm-up must wait for ready, then win one cycle later.
        first_t = -1;
        for (int i = 0; i < 24; i++) begin
            step((t >= 8) ? 4'b0010 : 4'b0000);
            if (gnt != '0 && first_t < 0) first_t = t;
        end
        chk("first_gnt_cycle", 64'(first_t), 64'(T_RDY + 1));
        step(4'b0000);
        step(4'b0000);

        // All four requesting: rotating grants, fresh words.
        prev_rnd = rnd;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111);
            if (gnt != '0) begin
                chk("rnd_fresh", 64'(rnd != prev_rnd), 64'(1));
                prev_rnd = rnd;
            end
        end
        step(4'b0000);
        step(4'b0000);

        // Single requester: every second cycle.
        pulses = 0;
        nexts  = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0100);
            if (gnt == 4'b0100) pulses++;
            if (lfsr_next)      nexts++;
        end
        chk("single_pulses", 64'(pulses), 64'(5));
        chk("single_nexts", 64'(nexts), 64'(5));

        for (int i = 0; i < 200; i++) step(NREQ'($urandom));

        // Abort a grant in flight.
        tries = 0;
        while (e_gnt < 0 && tries < 50) begin
            step(NREQ'($urandom_range(1, 15)));
            tries++;
        end
        chk("abort_reached_gnt", 64'(e_gnt >= 0), 64'(1));
        init = 1'b1;
        #1;
        chk("abort_gnt", 64'(gnt), 64'(0));
        chk("abort_rnd", 64'(rnd), 64'(0));
        chk("abort_ready", 64'(ready), 64'(0));
        chk("abort_lfsr_init", 64'(lfsr_init), 64'(1));
        repeat (2) @(negedge clk);
        init = 1'b0;
        model_reset();
        #1;
        check_all();

        first_t = -1;
        for (int i = 0; i < T_RDY + 4; i++) begin
            step(4'b1010);
            if (gnt != '0 && first_t < 0) begin
                first_t = t;
                chk("post_rst_winner", 64'(gnt), 64'(4'b0010));
            end
        end
        chk("post_rst_gnt_seen", 64'(first_t), 64'(T_RDY + 1));

        for (int i = 0; i < 150; i++) step(NREQ'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
